// File: rtl/alu_pipe.sv
// Pipelined integer ALU with valid/ready handshakes on both sides, tag pass-through and ROB flush.
// Define ALU_STATS_EN to add the stat_issued / stat_killed counters.
module alu_pipe #(
    parameter int XLEN   = 64,
    parameter int STAGES = 2,
    parameter int TAG_W  = 12
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [2:0]       in_func,
    input  logic             in_mod,
    input  logic             in_word,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag
`ifdef ALU_STATS_EN
    ,
    output logic [31:0]      stat_issued,
    output logic [31:0]      stat_killed
`endif
);
    localparam int SHW = $clog2(XLEN);

    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] full_res;
    logic [XLEN-1:0] alu_res;
    logic            in_fire;

    assign shamt   = in_b[SHW-1:0];
    assign in_fire = in_valid & in_ready;

    always_comb begin
        full_res = '0;
        case (in_func)
            3'd0: full_res = in_mod ? (in_a - in_b) : (in_a + in_b);
            3'd1: full_res = in_a << shamt;
            3'd2: full_res = {{(XLEN-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
            3'd3: full_res = {{(XLEN-1){1'b0}}, (in_a < in_b)};
            3'd4: full_res = in_a ^ in_b;
            3'd5: begin
                // Kept as separate branches so the signed shift is not coerced to unsigned.
                if (in_mod)
                    full_res = $signed(in_a) >>> shamt;
                else
                    full_res = in_a >> shamt;
            end
            3'd6: full_res = in_a | in_b;
            default: full_res = in_mod ? (~in_a & in_b) : (in_a & in_b);
        endcase
    end

    generate
        if (XLEN == 64) begin : g_word
            logic [31:0] wa;
            logic [31:0] wb;
            logic [31:0] wres;
            logic        word_op;

            assign wa      = in_a[31:0];
            assign wb      = in_b[31:0];
            assign word_op = in_word & ((in_func == 3'd0) | (in_func == 3'd1) | (in_func == 3'd5));

            always_comb begin
                wres = '0;
                case (in_func)
                    3'd0: wres = in_mod ? (wa - wb) : (wa + wb);
                    3'd1: wres = wa << wb[4:0];
                    default: begin
                        if (in_mod)
                            wres = $signed(wa) >>> wb[4:0];
                        else
                            wres = wa >> wb[4:0];
                    end
                endcase
            end

            assign alu_res = word_op ? {{32{wres[31]}}, wres} : full_res;
        end else begin : g_noword
            logic unused_word;
            assign unused_word = in_word;
            assign alu_res     = full_res;
        end
    endgenerate

    logic             vld_reg [1:STAGES];
    logic [XLEN-1:0]  res_reg [1:STAGES];
    logic [TAG_W-1:0] tag_reg [1:STAGES];
    logic             up_vld  [1:STAGES];
    logic [XLEN-1:0]  up_res  [1:STAGES];
    logic [TAG_W-1:0] up_tag  [1:STAGES];
    logic [STAGES:1]  ready;
    logic             adv_chain;

    // A stage can load when it is empty or its content moves on; the chain runs back from out_ready.
    always_comb begin
        ready     = '0;
        adv_chain = out_ready;
        for (int k = STAGES; k >= 1; k--) begin
            ready[k]  = ~vld_reg[k] | adv_chain;
            adv_chain = ready[k];
        end
    end

    generate
        for (genvar gi = 1; gi <= STAGES; gi++) begin : g_stage
            if (gi == 1) begin : g_head
                assign up_vld[gi] = in_valid;
                assign up_res[gi] = alu_res;
                assign up_tag[gi] = in_tag;
            end else begin : g_body
                assign up_vld[gi] = vld_reg[gi-1];
                assign up_res[gi] = res_reg[gi-1];
                assign up_tag[gi] = tag_reg[gi-1];
            end

            always_ff @(posedge clk) begin
                if (!rstn) begin
                    vld_reg[gi] <= 1'b0;
                    res_reg[gi] <= '0;
                    tag_reg[gi] <= '0;
                end else begin
                    if (flush)
                        vld_reg[gi] <= 1'b0;
                    else if (ready[gi])
                        vld_reg[gi] <= up_vld[gi];
                    // Data only moves with a valid op, so a stalled output stays stable.
                    if (ready[gi] && up_vld[gi]) begin
                        res_reg[gi] <= up_res[gi];
                        tag_reg[gi] <= up_tag[gi];
                    end
                end
            end
        end
    endgenerate

    assign in_ready   = ready[1];
    assign out_valid  = vld_reg[STAGES];
    assign out_result = res_reg[STAGES];
    assign out_tag    = tag_reg[STAGES];

`ifdef ALU_STATS_EN
    logic [31:0] live_cnt;

    always_comb begin
        live_cnt = '0;
        for (int k = 1; k <= STAGES; k++)
            live_cnt = live_cnt + 32'(vld_reg[k]);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            stat_issued <= '0;
            stat_killed <= '0;
        end else begin
            if (in_fire)
                stat_issued <= stat_issued + 32'd1;
            if (flush)
                stat_killed <= stat_killed + live_cnt + 32'(in_fire);
        end
    end
`else
    logic unused_fire;
    assign unused_fire = in_fire;
`endif
endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe (XLEN=64, STAGES=2): vector table under random back-pressure,
// scoreboard on the output handshake, plus hand sequences for latency, stall, flush and reset.
module tb_alu_pipe;
    typedef struct {
        logic [2:0]  func;
        logic        mod;
        logic        word;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
    } vec_t;

    typedef struct {
        logic [63:0] res;
        logic [11:0] tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstn, flush, in_valid, in_ready;
    logic [63:0] in_a, in_b;
    logic [2:0]  in_func;
    logic        in_mod, in_word;
    logic [11:0] in_tag;
    logic        out_valid, out_ready;
    logic [63:0] out_result;
    logic [11:0] out_tag;

    logic        rand_bp     = 1'b0;
    logic        manual_ready = 1'b1;
    logic [63:0] cur_exp;
    int          n_checks = 0;
    int          n_pass   = 0;
    exp_t        sb[$];
    vec_t        vecs[$];

    alu_pipe #(.XLEN(64), .STAGES(2), .TAG_W(12)) dut (
        .clk(clk), .rstn(rstn), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_func(in_func), .in_mod(in_mod), .in_word(in_word),
        .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    // Single driver of out_ready: random back-pressure or a bench-controlled level.
    always @(posedge clk) begin
        #2;
        out_ready = rand_bp ? ($urandom_range(0, 3) != 0) : manual_ready;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h, required %h", name, act, exp);
    endtask

    // Scoreboard: pop on output handshake, push on accepted input, drop everything on flush/reset.
    always @(negedge clk) begin
        exp_t e;
        if (!rstn) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    $display("FAIL out_underflow: got output %h tag %h, required no output", out_result, out_tag);
                end else begin
                    e = sb.pop_front();
                    check("result", out_result, e.res);
                    check("tag", 64'(out_tag), 64'(e.tag));
                    $display("out  tag=%h result=%h", out_tag, out_result);
                end
            end
            if (flush)
                sb.delete();
            else if (in_valid && in_ready)
                sb.push_back('{res: cur_exp, tag: in_tag});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input vec_t v, input logic [11:0] tag);
        in_func  = v.func;
        in_mod   = v.mod;
        in_word  = v.word;
        in_a     = v.a;
        in_b     = v.b;
        in_tag   = tag;
        cur_exp  = v.exp;
        in_valid = 1'b1;
    endtask

    function automatic vec_t mk_add(input logic [63:0] n);
        vec_t v;
        v = '{3'd0, 1'b0, 1'b0, n, n, n + n};
        return v;
    endfunction

    task automatic send_op(input vec_t v, input logic [11:0] tag);
        bit acc = 0;
        set_op(v, tag);
        for (int t = 0; t < 64; t++) begin
            @(negedge clk);
            if (in_ready) begin
                acc = 1;
                break;
            end
        end
        if (!acc) check("accept_timeout", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int t = 0; t < 200; t++) begin
            @(posedge clk);
            if (sb.size() == 0) break;
        end
        check(name, 64'(sb.size()), 64'd0);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ov_cnt;
        vecs.push_back('{3'd0, 1'b0, 1'b0, 64'd5, 64'd7, 64'd12});
        vecs.push_back('{3'd0, 1'b1, 1'b0, 64'd5, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE});
        vecs.push_back('{3'd0, 1'b0, 1'b1, 64'h7FFF_FFFF, 64'd1, 64'hFFFF_FFFF_8000_0000});
        vecs.push_back('{3'd5, 1'b1, 1'b1, 64'h8000_0000, 64'd4, 64'hFFFF_FFFF_F800_0000});
        vecs.push_back('{3'd5, 1'b0, 1'b1, 64'h8000_0000, 64'd4, 64'h0000_0000_0800_0000});
        vecs.push_back('{3'd2, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1});
        vecs.push_back('{3'd3, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0});
        vecs.push_back('{3'd7, 1'b1, 1'b0, 64'hF0, 64'hFF, 64'h0F});
        vecs.push_back('{3'd5, 1'b1, 1'b0, 64'h8000_0000_0000_0000, 64'd63, 64'hFFFF_FFFF_FFFF_FFFF});
        vecs.push_back('{3'd1, 1'b0, 1'b0, 64'd1, 64'd63, 64'h8000_0000_0000_0000});
        vecs.push_back('{3'd1, 1'b0, 1'b1, 64'd1, 64'd31, 64'hFFFF_FFFF_8000_0000});
        vecs.push_back('{3'd4, 1'b0, 1'b0, 64'hF0F0, 64'hFF00, 64'h0FF0});
        vecs.push_back('{3'd6, 1'b1, 1'b0, 64'hF0, 64'h0F, 64'hFF});
        vecs.push_back('{3'd7, 1'b0, 1'b0, 64'hF0, 64'h3C, 64'h30});
        vecs.push_back('{3'd5, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 64'd63, 64'd1});
        vecs.push_back('{3'd5, 1'b1, 1'b0, 64'h4000_0000_0000_0000, 64'd62, 64'd1});
        vecs.push_back('{3'd1, 1'b0, 1'b0, 64'd1, 64'h41, 64'd2});
        vecs.push_back('{3'd0, 1'b1, 1'b1, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF});
        vecs.push_back('{3'd0, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0});
        vecs.push_back('{3'd4, 1'b0, 1'b1, 64'hFFFF_FFFF_0000_0000, 64'd0, 64'hFFFF_FFFF_0000_0000});
        vecs.push_back('{3'd2, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1});
        vecs.push_back('{3'd2, 1'b0, 1'b0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0});
        vecs.push_back('{3'd3, 1'b0, 1'b0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1});
        vecs.push_back('{3'd0, 1'b0, 1'b1, 64'h1234_5678_0000_0001, 64'hABCD_0000_0000_0002, 64'd3});
        vecs.push_back('{3'd5, 1'b0, 1'b1, 64'hFFFF_FFFF_8000_0000, 64'h24, 64'h0800_0000});

        rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
        in_func = '0; in_mod = 1'b0; in_word = 1'b0; in_tag = '0; cur_exp = '0;
        out_ready = 1'b1;
        repeat (3) step();
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_result", out_result, 64'd0);
        check("rst_out_tag", 64'(out_tag), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        rstn = 1'b1;
        step();

        // Latency and back-to-back throughput with out_ready high.
        set_op(vecs[0], 12'h3);
        @(negedge clk); check("lat_c0_valid", 64'(out_valid), 64'd0);
        step();
        set_op(vecs[1], 12'h4);
        @(negedge clk); check("lat_c1_valid", 64'(out_valid), 64'd0);
        step();
        in_valid = 1'b0;
        @(negedge clk); check("lat_c2_valid", 64'(out_valid), 64'd1);
        step();
        @(negedge clk); check("lat_c3_valid", 64'(out_valid), 64'd1);
        step();
        @(negedge clk); check("lat_c4_valid", 64'(out_valid), 64'd0);
        step();

        // Vector table under random back-pressure.
        rand_bp = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            $display("in   vec=%0d func=%0d mod=%0d word=%0d a=%h b=%h", i, vecs[i].func,
                     vecs[i].mod, vecs[i].word, vecs[i].a, vecs[i].b);
            send_op(vecs[i], 12'(i + 16));
        end
        rand_bp = 1'b0;
        manual_ready = 1'b1;
        drain("table_drain");

        // Back-pressure: pipe fills to two ops, output holds, then drains in order.
        manual_ready = 1'b0;
        step();
        set_op(mk_add(64'd1), 12'h10);
        @(negedge clk); check("bp_acc0", 64'(in_ready), 64'd1);
        step();
        set_op(mk_add(64'd2), 12'h11);
        @(negedge clk); check("bp_acc1", 64'(in_ready), 64'd1);
        step();
        set_op(mk_add(64'd3), 12'h12);
        @(negedge clk);
        check("bp_full", 64'(in_ready), 64'd0);
        check("bp_valid", 64'(out_valid), 64'd1);
        check("bp_hold0", out_result, 64'd2);
        step();
        @(negedge clk);
        check("bp_hold1", out_result, 64'd2);
        check("bp_hold_tag", 64'(out_tag), 64'h10);
        check("bp_full1", 64'(in_ready), 64'd0);
        manual_ready = 1'b1;
        step();
        @(negedge clk);
        check("bp_out0", 64'(out_valid), 64'd1);
        check("bp_acc2", 64'(in_ready), 64'd1);
        step();
        set_op(mk_add(64'd4), 12'h13);
        @(negedge clk);
        check("bp_out1", 64'(out_valid), 64'd1);
        check("bp_acc3", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        @(negedge clk); check("bp_out2", 64'(out_valid), 64'd1);
        step();
        @(negedge clk); check("bp_out3", 64'(out_valid), 64'd1);
        step();
        @(negedge clk); check("bp_out4", 64'(out_valid), 64'd0);
        check("bp_sb_empty", 64'(sb.size()), 64'd0);
        step();

        // Flush with two ops in flight and a third offered in the same cycle.
        set_op(mk_add(64'd5), 12'h20);
        step();
        set_op(mk_add(64'd6), 12'h21);
        step();
        set_op(mk_add(64'd7), 12'h22);
        flush = 1'b1;
        @(negedge clk);
        check("fl_out_consumed", 64'(out_valid), 64'd1);
        check("fl_in_ready", 64'(in_ready), 64'd1);
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk); check("fl_killed", 64'(out_valid), 64'd0);
        ov_cnt = 0;
        for (int t = 0; t < 5; t++) begin
            step();
            @(negedge clk);
            if (out_valid) ov_cnt++;
        end
        check("fl_nothing_later", 64'(ov_cnt), 64'd0);
        step();
        send_op(vecs[2], 12'h30);
        drain("fl_recover_drain");

        // Reset with a full, stalled pipe.
        manual_ready = 1'b0;
        step();
        set_op(mk_add(64'd8), 12'h40);
        step();
        set_op(mk_add(64'd9), 12'h41);
        step();
        in_valid = 1'b0;
        rstn = 1'b0;
        step();
        @(negedge clk);
        check("rs_out_valid", 64'(out_valid), 64'd0);
        check("rs_out_result", out_result, 64'd0);
        check("rs_out_tag", 64'(out_tag), 64'd0);
        check("rs_in_ready", 64'(in_ready), 64'd1);
        rstn = 1'b1;
        manual_ready = 1'b1;
        step();
        send_op(vecs[8], 12'h50);
        drain("rs_recover_drain");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
Parametrised, pipelined integer ALU for the out-of-order backend. Supports configurable datapath width and pipeline depth. Uses a full valid/ready handshake on both sides, so it tolerates writeback back-pressure without a global stall. Carries a destination/ROB tag alongside each operation and supports a global flush from the ROB.

Parameters:
XLEN, 64, datapath width (32 or 64).
STAGES, 2, pipeline depth in register stages (1..4); defines zero-stall latency.
TAG_W, 12, width of the opaque tag (phys rd + ROB index), passed through unchanged.

Ports:
clk  in  1  clock
rstn  in  1  synchronous reset, active-low
flush  in  1  kill every in-flight op this cycle
in_valid  in  1  operation offered
in_ready  out  1  operation accepted when in_valid & in_ready
in_a  in  XLEN  operand A
in_b  in  XLEN  operand B (register or immediate)
in_func  in  3  0 ADD/SUB, 1 SLL, 2 SLT, 3 SLTU, 4 XOR, 5 SRL/SRA, 6 OR, 7 AND/ANDN
in_mod  in  1  modifier: SUB, SRA, ANDN (~a & b); ignored for other funcs
in_word  in  1  RV64 *W op; ignored when XLEN==32
in_tag  in  TAG_W  tag
out_valid  out  1  result available
out_ready  in  1  consumer accepts when out_valid & out_ready
out_result  out  XLEN  result
out_tag  out  TAG_W  tag of out_result

Behaviour:
- Reset (rstn=0 at posedge): all stage valid bits 0, all stage data and tags 0. out_valid=0, out_result=0, out_tag=0. Reset has priority over flush and handshakes. In-flight ops are discarded.
- Compute happens in the accept cycle. The registered result enters stage 1. Stages 2..STAGES are pure delay/buffer stages.
- Stage k advances when stage k+1 is empty or stage k+1 advances. The last stage advances on out_ready. Bubbles collapse.
- in_ready = ~stage1_valid | stage1_advances. This is combinational from out_ready through the chain, with no registered skid.
- Latency: with out_ready held 1, an op accepted at cycle N has out_valid=1 at cycle N+STAGES. Throughput is 1 op/cycle.
- Back-pressure: with out_ready=0, the pipe fills to STAGES ops, then in_ready=0. out_result and out_tag stay stable while out_valid & ~out_ready.
- Flush: clears all valid bits at the posedge. An op handshaked in the flush cycle is discarded. An output handshaked in the flush cycle counts as consumed. Data registers need not clear.
- Arithmetic:
  - ADD/SUB: modulo 2^XLEN.
  - Shift amount: b[log2(XLEN)-1:0], or b[4:0] when word.
  - SLT/SLTU: result in bit 0, zero-extended.
  - SRA: arithmetic on a[XLEN-1].
- Word mode (XLEN==64, in_word=1), valid for func 0, 1, 5:
  - Operate on a[31:0]; SRAW sign is a[31].
  - 32-bit result is sign-extended from bit 31.
  - in_word is ignored for the other funcs.
- Simultaneous accept and output in the same cycle on a full pipe is legal and keeps occupancy constant.

Optional Feature:
ALU_STATS_EN
- Defined: adds outputs stat_issued (32) and stat_killed (32).
  - stat_issued increments per input handshake.
  - stat_killed adds the number of valid stages cleared by flush, plus 1 if an input handshake coincides with the flush.
  - Both reset to 0, wrap at 2^32, and are not cleared by flush.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
1. XLEN=64, STAGES=2, out_ready=1. Send ADD a=5, b=7, tag=0x3 at cycle 0 -> cycle 2: out_valid=1, result=12, tag=0x3. Back-to-back SUB 5-7 at cycle 1 -> cycle 3: result=0xFFFF_FFFF_FFFF_FFFE.
2. Word ops:
   - ADDW a=0x7FFF_FFFF, b=1 -> 0xFFFF_FFFF_8000_0000.
   - SRAW a=0x8000_0000, b=4 -> 0xFFFF_FFFF_F800_0000.
   - SRLW same operands -> 0x0000_0000_0800_0000.
3. SLT a=-1, b=1 -> 1; SLTU same -> 0; ANDN a=0xF0, b=0xFF -> 0x0F; SRA a=0x8000_0000_0000_0000, b=63 -> all ones.
4. out_ready=0, stream 4 ops -> in_ready drops after 2 accepts and out_result holds. Raise out_ready -> results emerge in order, one per cycle, no loss or duplication.
5. Fill 2 ops, then assert flush with in_valid=1 -> next cycle out_valid=0 and nothing emerges later. With ALU_STATS_EN: stat_killed=3, stat_issued=3.
6. Assert rstn=0 mid-stream with a full pipe -> next cycle out_valid=0, out_result=0, out_tag=0, in_ready=1.
